// File: rtl/axi_sync_fifo.sv
// Single-clock valid/ready FIFO with occupancy, threshold flags, flush and optional FWFT bypass.
// Define AXI_SYNC_FIFO_STATS_EN to add the max_level_o high-watermark output.
module axi_sync_fifo #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned FALL_THROUGH  = 0,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          s_valid_i,
  input  logic [DATA_WIDTH-1:0]         s_data_i,
  output logic                          s_ready_o,
  output logic                          m_valid_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o
`ifdef AXI_SYNC_FIFO_STATS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   max_level_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_THRESH);
  localparam logic [LVL_W-1:0] ONE_L    = LVL_W'(1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi_sync_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [LVL_W-1:0]      r_wr_ptr;
  logic [LVL_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_afull;
  logic                  r_aempty;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_s_ready;
  logic                  w_m_valid;
  logic [DATA_WIDTH-1:0] w_m_data;
  logic                  w_push;
  logic                  w_pop;
  logic [LVL_W-1:0]      w_wr_ptr_nxt;
  logic [LVL_W-1:0]      w_rd_ptr_nxt;
  logic [LVL_W-1:0]      w_level_nxt;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_s_ready = !w_full && !flush_i;

  // Read side: output register, or the write port itself when FWFT and empty
  always_comb begin
    w_m_valid = r_m_valid;
    w_m_data  = r_m_data;
    if ((FALL_THROUGH != 0) && w_empty) begin
      w_m_valid = s_valid_i && !flush_i;
      w_m_data  = s_data_i;
    end
  end

  assign w_push = s_valid_i && w_s_ready;
  assign w_pop  = w_m_valid && m_ready_i;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (flush_i) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + ONE_L;
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + ONE_L;
      if (w_push && !w_pop)      w_level_nxt = r_level + ONE_L;
      else if (w_pop && !w_push) w_level_nxt = r_level - ONE_L;
    end
  end

  // Head word for the next cycle; it may be the word being written right now
  assign w_load_data = (w_rd_ptr_nxt == r_wr_ptr) ? s_data_i
                                                  : r_mem[w_rd_ptr_nxt[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= s_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_level   <= w_level_nxt;
      r_m_valid <= (w_level_nxt != '0);
      if (w_level_nxt != '0) r_m_data <= w_load_data;
      r_afull   <= (w_level_nxt >= AFULL_L);
      r_aempty  <= (w_level_nxt <= AEMPTY_L);
    end
  end

`ifdef AXI_SYNC_FIFO_STATS_EN
  logic [LVL_W-1:0] r_max_level;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_max_level <= '0;
    else if (flush_i)           r_max_level <= '0;
    else if (r_level > r_max_level) r_max_level <= r_level;
  end

  assign max_level_o = r_max_level;
`endif

  assign s_ready_o      = w_s_ready;
  assign m_valid_o      = w_m_valid;
  assign m_data_o       = w_m_data;
  assign level_o        = r_level;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;

endmodule

// File: tb/tb_axi_sync_fifo.sv
// Scoreboard bench for axi_sync_fifo: registered-output instance plus an FWFT instance.
module tb_axi_sync_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_ready;
  logic [3:0]  level;
  logic        afull;
  logic        aempty;

  logic        ft_flush;
  logic        ft_s_valid;
  logic [63:0] ft_s_data;
  logic        ft_s_ready;
  logic        ft_m_valid;
  logic [63:0] ft_m_data;
  logic        ft_m_ready;
  logic [3:0]  ft_level;
  logic        ft_afull;
  logic        ft_aempty;

`ifdef AXI_SYNC_FIFO_STATS_EN
  logic [3:0]  max_lvl;
  logic [3:0]  ft_max_lvl;
`endif

  int total;
  int bad;
  logic [63:0] exp_q [$];
  logic [63:0] ft_q  [$];

  axi_sync_fifo #(.DATA_WIDTH(64), .FIFO_DEPTH(8), .FALL_THROUGH(0),
                  .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
    .level_o(level), .almost_full_o(afull), .almost_empty_o(aempty)
`ifdef AXI_SYNC_FIFO_STATS_EN
    , .max_level_o(max_lvl)
`endif
  );

  axi_sync_fifo #(.DATA_WIDTH(64), .FIFO_DEPTH(8), .FALL_THROUGH(1),
                  .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(ft_flush),
    .s_valid_i(ft_s_valid), .s_data_i(ft_s_data), .s_ready_o(ft_s_ready),
    .m_valid_o(ft_m_valid), .m_data_o(ft_m_data), .m_ready_i(ft_m_ready),
    .level_o(ft_level), .almost_full_o(ft_afull), .almost_empty_o(ft_aempty)
`ifdef AXI_SYNC_FIFO_STATS_EN
    , .max_level_o(ft_max_lvl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted output word must match the head of its queue
  always @(negedge clk) begin
    if (!rst && !flush && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL main_unexpected actual=%h required=none", m_data);
      end else begin
        chk("main_data", m_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !ft_flush && ft_m_valid && ft_m_ready) begin
      if (ft_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ft_unexpected actual=%h required=none", ft_m_data);
      end else begin
        chk("ft_data", ft_m_data, ft_q.pop_front());
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    ft_flush = 1'b0; ft_s_valid = 1'b0; ft_s_data = '0; ft_m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_aempty", 64'(aempty), 64'd1);
    rst = 1'b0;
    step();

    // Fill to full with the read side stalled
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 64'hA0 + 64'(i);
      exp_q.push_back(64'hA0 + 64'(i));
      step();
      chk("fill_level", 64'(level), 64'(i + 1));
      chk("fill_afull", 64'(afull), 64'((i + 1) >= 6));
      chk("fill_aempty", 64'(aempty), 64'((i + 1) <= 1));
    end
    chk("full_s_ready", 64'(s_ready), 64'd0);

    // Full with push and pop offered together: pop only
    s_data  = 64'hEE;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("fullpop_level", 64'(level), 64'd7);
    chk("fullpop_s_ready", 64'(s_ready), 64'd1);
    chk("fullpop_head", m_data, 64'hA1);

    // Streaming push+pop across pointer wraps
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 64'hB0 + 64'(i);
      exp_q.push_back(64'hB0 + 64'(i));
      step();
      chk("stream_level", 64'(level), 64'd7);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("drain_level", 64'(level), 64'(6 - i));
      chk("drain_afull", 64'(afull), 64'((6 - i) >= 6));
      chk("drain_aempty", 64'(aempty), 64'((6 - i) <= 1));
    end
    chk("drain_m_valid", 64'(m_valid), 64'd0);
    m_ready = 1'b0;

    // Flush at level 4 with a concurrent push that must be dropped
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 64'hC0 + 64'(i);
      exp_q.push_back(64'hC0 + 64'(i));
      step();
    end
    chk("preflush_level", 64'(level), 64'd4);
    s_data = 64'h77;
    flush  = 1'b1;
    #1;
    chk("flush_s_ready", 64'(s_ready), 64'd0);
    step();
    exp_q.delete();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_m_valid", 64'(m_valid), 64'd0);
    chk("flush_afull", 64'(afull), 64'd0);
    chk("flush_aempty", 64'(aempty), 64'd1);
`ifdef AXI_SYNC_FIFO_STATS_EN
    chk("flush_max_level", 64'(max_lvl), 64'd0);
`endif
    m_ready = 1'b1;
    repeat (3) step();
    chk("postflush_m_valid", 64'(m_valid), 64'd0);
    m_ready = 1'b0;

    // FWFT bypass when empty, then a stored word
    ft_s_valid = 1'b1;
    ft_s_data  = 64'h55;
    ft_m_ready = 1'b1;
    ft_q.push_back(64'h55);
    #1;
    chk("ft_bypass_valid", 64'(ft_m_valid), 64'd1);
    chk("ft_bypass_data", ft_m_data, 64'h55);
    step();
    chk("ft_bypass_level", 64'(ft_level), 64'd0);
    ft_m_ready = 1'b0;
    ft_s_data  = 64'h66;
    ft_q.push_back(64'h66);
    step();
    ft_s_valid = 1'b0;
    chk("ft_store_level", 64'(ft_level), 64'd1);
    chk("ft_store_valid", 64'(ft_m_valid), 64'd1);
    chk("ft_store_data", ft_m_data, 64'h66);
    ft_m_ready = 1'b1;
    step();
    chk("ft_drain_level", 64'(ft_level), 64'd0);
    chk("ft_drain_valid", 64'(ft_m_valid), 64'd0);
    ft_m_ready = 1'b0;

    // Asynchronous reset with five words stored
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 64'hD0 + 64'(i);
      exp_q.push_back(64'hD0 + 64'(i));
      step();
    end
    s_valid = 1'b0;
    chk("prerst_level", 64'(level), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_afull", 64'(afull), 64'd0);
    chk("midrst_aempty", 64'(aempty), 64'd1);
    exp_q.delete();
    #2;
    rst = 1'b0;
    step();
    s_valid = 1'b1;
    s_data  = 64'hE5;
    exp_q.push_back(64'hE5);
    step();
    s_valid = 1'b0;
    chk("postrst_m_valid", 64'(m_valid), 64'd1);
    chk("postrst_m_data", m_data, 64'hE5);
    chk("postrst_level", 64'(level), 64'd1);
    m_ready = 1'b1;
    step();
    chk("postrst_drain", 64'(level), 64'd0);
    m_ready = 1'b0;

    repeat (2) step();
    chk("main_queue_left", 64'(exp_q.size()), 64'd0);
    chk("ft_queue_left", 64'(ft_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
